// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch and data), the arbiter and the
// shared single-port memory. The arbiter takes the slave view; the environment
// (core requesters plus memory model) takes the master view.
interface mem_port_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  // Data port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        err;
  // Shared memory command and response
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  // Pipeline hold request back to the core
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, err,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, err,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port memory. Data accesses win
// over instruction fetches, except that after STARVE_LIMIT consecutive data
// grants made while a fetch is waiting, the fetch is served. Each access is
// held on the memory bus until mem_ready, or aborted with err after WAIT_MAX
// cycles. All outputs except stall are registered.
module mem_port_arbiter #(
  parameter int unsigned WAIT_MAX     = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam int unsigned STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic                gnt_data_q,  gnt_data_d;   // 1 = data owns the access
  logic [STARVE_W-1:0] starve_q,    starve_d;
  logic [WAIT_W-1:0]   wait_q,      wait_d;       // ACCESS cycles already spent
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [15:0]         mem_addr_q,  mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic [15:0]         if_rdata_q,  if_rdata_d;
  logic                if_valid_q,  if_valid_d;
  logic [15:0]         d_rdata_q,   d_rdata_d;
  logic                d_valid_q,   d_valid_d;
  logic                err_q,       err_d;

  logic done_q;   // a completion pulse is on the bus this cycle
  logic abort;    // current access ends without mem_ready
  logic pick_data;

  assign done_q = if_valid_q | d_valid_q;
  assign abort  = ~bus.mem_ready;

  // Data wins unless a waiting fetch has already been passed over too often.
  assign pick_data = bus.d_req & ~(bus.if_req & (starve_q == STARVE_TOP));

  // Next-state and output computation for the IDLE/ACCESS controller.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // Requesters still hold req during their valid cycle, so arbitration
        // waits one cycle after a completion to avoid re-serving it.
        if (!done_q && (bus.if_req || bus.d_req)) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          wait_d   = '0;
          if (pick_data) begin
            gnt_data_d  = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.if_req && (starve_q != STARVE_TOP)) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            // Fetch is read-only; the write-data register is left as is.
            gnt_data_d = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.if_addr;
            starve_d   = '0;
          end
        end
      end

      ACCESS: begin
        if (bus.mem_ready || (wait_q == WAIT_LAST)) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          err_d    = abort;
          if (gnt_data_q) begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = abort ? 16'h0000 : bus.mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = abort ? 16'h0000 : bus.mem_rdata;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_data_q  <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= 16'h0000;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      gnt_data_q  <= gnt_data_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.err       = err_q;

  // A requester is stalled from request until the cycle its valid shows.
  assign bus.stall = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level model tracks each
// requester as idle / waiting / being served, decides grants from the priority
// and starvation rules, and owns the memory: it picks a response latency per
// access (sometimes beyond WAIT_MAX) and the read data, then predicts when
// valid/err appear and what the read-data registers hold.
module tb_mem_port_arbiter;

  localparam int WAIT_MAX     = 8;
  localparam int STARVE_LIMIT = 3;
  localparam int N_CYC        = 3000;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .WAIT_MAX    (WAIT_MAX),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef enum int { RQ_IDLE, RQ_WAIT, RQ_BUSY } rq_e;

  // Requester model
  rq_e         f_st, d_st;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        d_we;
  int          starve;          // data grants in a row while fetch waited
  logic [15:0] last_wdata, exp_if_rdata, exp_d_rdata;

  // Access in flight
  bit          acc_on, acc_data, acc_we;
  int          acc_idx, acc_lat, acc_end;
  logic [15:0] acc_addr, acc_wdata, acc_rdata;
  bit          was_valid;
  bit          rst_due;

  int n_done, n_timeout, n_forced;

  function automatic int pick_latency();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 4) return r;
    if (r == 5) return WAIT_MAX - 1;   // ready on the very last allowed cycle
    if (r == 6) return WAIT_MAX - 2;
    if (r == 7) return WAIT_MAX;       // never ready -> abort
    return 0;
  endfunction

  initial begin
    bit fin, f_fin, d_fin, fw, dw, exp_en, gnt_data, t_out;

    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 16'h0000;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 16'h0000;
    bus.d_wdata   = 16'h0000;
    bus.mem_rdata = 16'h0000;
    bus.mem_ready = 1'b0;
    f_st = RQ_IDLE; d_st = RQ_IDLE;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    starve = 0; last_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    acc_on = 0; acc_data = 0; acc_we = 0; acc_idx = 0; acc_lat = 0; acc_end = 0;
    acc_addr = '0; acc_wdata = '0; acc_rdata = '0;
    was_valid = 0; rst_due = 0; n_done = 0; n_timeout = 0; n_forced = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_en",    32'(bus.mem_en),    32'd0);
    check("reset_mem_we",    32'(bus.mem_we),    32'd0);
    check("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset_if_rdata",  32'(bus.if_rdata),  32'd0);
    check("reset_d_rdata",   32'(bus.d_rdata),   32'd0);
    check("reset_if_valid",  32'(bus.if_valid),  32'd0);
    check("reset_d_valid",   32'(bus.d_valid),   32'd0);
    check("reset_err",       32'(bus.err),       32'd0);
    check("reset_stall",     32'(bus.stall),     32'd0);

    // A fetch raised during reset must not be granted until release.
    f_st = RQ_WAIT; f_addr = 16'h0010;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    @(posedge clk);
    #1;
    check("no_grant_in_reset", 32'(bus.mem_en), 32'd0);
    #2 rst = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;

      // Expected outputs for this cycle, from last cycle's model state.
      fin   = acc_on && (acc_idx == acc_end);
      t_out = fin && (acc_lat >= WAIT_MAX);
      f_fin = fin && !acc_data;
      d_fin = fin && acc_data;
      fw    = (f_st == RQ_WAIT);
      dw    = (d_st == RQ_WAIT);
      exp_en = (!acc_on && !was_valid && (fw || dw)) || (acc_on && !fin);
      if (fin) begin
        n_done++;
        if (t_out) n_timeout++;
        if (acc_data) begin
          if (!acc_we) exp_d_rdata = t_out ? 16'h0000 : acc_rdata;
        end else begin
          exp_if_rdata = t_out ? 16'h0000 : acc_rdata;
        end
      end

      check("if_valid", 32'(bus.if_valid), 32'(f_fin));
      check("d_valid",  32'(bus.d_valid),  32'(d_fin));
      check("err",      32'(bus.err),      32'(t_out));
      check("if_rdata", 32'(bus.if_rdata), 32'(exp_if_rdata));
      check("d_rdata",  32'(bus.d_rdata),  32'(exp_d_rdata));
      check("mem_en",   32'(bus.mem_en),   32'(exp_en));

      // Advance the model.
      if (fin) begin
        acc_on = 0;
        if (acc_data) d_st = RQ_IDLE;
        else          f_st = RQ_IDLE;
      end else if (!acc_on && !was_valid && (fw || dw)) begin
        gnt_data = dw && !(fw && (starve == STARVE_LIMIT));
        if (gnt_data) begin
          acc_addr = d_addr; acc_we = d_we; acc_wdata = d_wdata;
          last_wdata = d_wdata;
          d_st = RQ_BUSY;
          if (fw && (starve < STARVE_LIMIT)) starve++;
        end else begin
          if (dw) n_forced++;
          acc_addr = f_addr; acc_we = 1'b0; acc_wdata = last_wdata;
          f_st = RQ_BUSY;
          starve = 0;
        end
        acc_data  = gnt_data;
        acc_on    = 1;
        acc_idx   = 0;
        acc_lat   = pick_latency();
        acc_end   = (acc_lat < WAIT_MAX) ? acc_lat : WAIT_MAX - 1;
        acc_rdata = 16'($urandom);
      end else if (acc_on) begin
        acc_idx++;
      end
      was_valid = fin;

      // Command must be the granted request's and stay frozen during ACCESS.
      if (acc_on) begin
        check("mem_addr",  32'(bus.mem_addr),  32'(acc_addr));
        check("mem_we",    32'(bus.mem_we),    32'(acc_we));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(acc_wdata));
      end

      // Memory response; stray mem_ready pulses while idle must be ignored.
      if (acc_on && (acc_idx == acc_lat)) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = acc_rdata;
      end else if (!acc_on && ($urandom_range(0, 2) == 0)) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'($urandom);
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end

      // Requesters: drop req on completion, maybe raise a new one later.
      bus.if_req = (f_st != RQ_IDLE);
      bus.d_req  = (d_st != RQ_IDLE);
      if ((f_st == RQ_IDLE) && !f_fin && ($urandom_range(0, 1) == 1)) begin
        f_st = RQ_WAIT;
        f_addr = 16'($urandom);
        bus.if_req = 1'b1; bus.if_addr = f_addr;
      end
      if ((d_st == RQ_IDLE) && !d_fin && ($urandom_range(0, 3) != 0)) begin
        d_st = RQ_WAIT;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
        bus.d_req = 1'b1; bus.d_we = d_we; bus.d_addr = d_addr; bus.d_wdata = d_wdata;
      end

      #1;
      check("stall", 32'(bus.stall),
            32'(((f_st != RQ_IDLE) && !f_fin) || ((d_st != RQ_IDLE) && !d_fin)));

      // Occasionally pull reset in the middle of an access.
      if ((cyc % 500) == 250) rst_due = 1;
      if (rst_due && acc_on) begin
        rst_due = 0;
        #1 rst = 1'b0;
        #1;
        check("rst_mem_en_async", 32'(bus.mem_en),   32'd0);
        check("rst_if_valid",     32'(bus.if_valid), 32'd0);
        check("rst_d_valid",      32'(bus.d_valid),  32'd0);
        check("rst_err",          32'(bus.err),      32'd0);
        check("rst_mem_addr",     32'(bus.mem_addr), 32'd0);
        // Only a fetch remains pending across the reset.
        d_st = RQ_IDLE; bus.d_req = 1'b0;
        if (f_st == RQ_IDLE) begin
          f_addr = 16'($urandom);
          bus.if_addr = f_addr;
        end
        f_st = RQ_WAIT; bus.if_req = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_mem_en", 32'(bus.mem_en),   32'd0);
        check("rst_hold_valid",  32'(bus.if_valid | bus.d_valid), 32'd0);
        acc_on = 0; starve = 0; last_wdata = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; was_valid = 0;
        #2 rst = 1'b1;
      end
    end

    check("accesses_completed", 32'(n_done > 100),  32'd1);
    check("timeouts_seen",      32'(n_timeout > 0), 32'd1);
    check("forced_fetch_seen",  32'(n_forced > 0),  32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
